// File: rtl/rooth_div_ctrl_pkg.sv
// Shared divider definitions: datapath width, op encodings, FSM states.
// Op helpers keep sign/remainder decoding in one place.
package rooth_div_ctrl_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  function automatic logic op_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/rooth_div_step.sv
// One restoring shift-subtract iteration: shifts in the next dividend
// bit, trial-subtracts the divisor and emits one quotient bit.
module rooth_div_step
  import rooth_div_ctrl_pkg::*;
(
  input  logic [CPU_WIDTH-1:0] rem_i,
  input  logic [CPU_WIDTH-1:0] quot_i,
  input  logic [CPU_WIDTH-1:0] divisor_i,
  output logic [CPU_WIDTH-1:0] rem_o,
  output logic [CPU_WIDTH-1:0] quot_o
);

  logic [CPU_WIDTH:0] shifted;
  logic [CPU_WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quot_i[CPU_WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    rem_o   = diff[CPU_WIDTH] ? shifted[CPU_WIDTH-1:0]
                              : diff[CPU_WIDTH-1:0];
    quot_o  = {quot_i[CPU_WIDTH-2:0], ~diff[CPU_WIDTH]};
  end

endmodule

// File: rtl/rooth_div_ctrl.sv
// Multi-cycle divider controller: FSM, iteration counter, sign fix-up
// and divide-by-zero / overflow shortcut around rooth_div_step.
module rooth_div_ctrl
  import rooth_div_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = CPU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [CPU_WIDTH-1:0] dividend_i,
  input  logic [CPU_WIDTH-1:0] divisor_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CPU_WIDTH-1:0] result_o,
  output logic [4:0]           rd_addr_o
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  div_state_e           state_q, state_d;
  div_op_e              op_e, op_q;
  logic [CW-1:0]        cnt_q;
  logic [CPU_WIDTH-1:0] quot_q, rem_q, dvsr_q, res_q;
  logic [4:0]           rd_q;
  logic                 quo_neg_q, rem_neg_q;

  logic                 accept, special, div_zero, ovf;
  logic                 dvd_neg, dvs_neg;
  logic [CPU_WIDTH-1:0] dvd_mag, dvs_mag;
  logic [CPU_WIDTH-1:0] spec_res, fix_res;
  logic [CPU_WIDTH-1:0] step_rem, step_quot;

  assign op_e     = div_op_e'(op_i);
  assign accept   = (state_q == IDLE) && start_i && !flush_i;
  assign div_zero = (divisor_i == '0);
  assign ovf      = op_signed(op_e)
                 && (dividend_i == {1'b1, {(CPU_WIDTH-1){1'b0}}})
                 && (divisor_i == '1);
  assign special  = div_zero || ovf;

  assign dvd_neg = op_signed(op_e) && dividend_i[CPU_WIDTH-1];
  assign dvs_neg = op_signed(op_e) && divisor_i[CPU_WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i : divisor_i;

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      (div_zero && !op_rem(op_e)):  spec_res = '1;
      (div_zero && op_rem(op_e)):   spec_res = dividend_i;
      (!div_zero && !op_rem(op_e)): spec_res = {1'b1, {(CPU_WIDTH-1){1'b0}}};
      default:                      spec_res = '0;
    endcase
  end

  always_comb begin
    if (op_rem(op_q))
      fix_res = rem_neg_q ? -rem_q : rem_q;
    else
      fix_res = quo_neg_q ? -quot_q : quot_q;
  end

  rooth_div_step u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = accept;
        if (accept) state_d = special ? DONE : CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt_q == CW'(DIV_CYCLES - 1)) state_d = FIX;
      end
      FIX: begin
        busy_o  = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign done_o    = (state_q == DONE) && !flush_i;
  assign result_o  = res_q;
  assign rd_addr_o = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_DIV;
      rd_q      <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept) begin
      op_q      <= op_e;
      rd_q      <= rd_addr_i;
      cnt_q     <= '0;
      quot_q    <= dvd_mag;
      rem_q     <= '0;
      dvsr_q    <= dvs_mag;
      quo_neg_q <= dvd_neg ^ dvs_neg;
      rem_neg_q <= dvd_neg;
      if (special) res_q <= spec_res;
    end else if (state_q == CALC) begin
      quot_q <= step_quot;
      rem_q  <= step_rem;
      cnt_q  <= cnt_q + CW'(1);
    end else if (state_q == FIX && !flush_i) begin
      res_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_rooth_div_ctrl.sv
// Bench for rooth_div_ctrl: arithmetic reference model checked every
// cycle, plus directed ops with literal results and latencies.
module tb_rooth_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  rooth_div_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit is_special(logic [1:0] op, logic [31:0] a,
                                    logic [31:0] b);
    return (b == 0) ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(logic [1:0] op,
                                             logic [31:0] a,
                                             logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  bit          m_act = 0;
  bit          m_spec = 0;
  int          m_t0 = 0;
  logic [31:0] m_res = '0, m_last_res = '0;
  logic [4:0]  m_rd = '0, m_last_rd = '0;

  always @(negedge clk) begin : model
    int   k, dk;
    logic acc, be, de;
    if (!rst_n) begin
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_rd", rd_addr_o, 0);
      m_act = 0;
      m_last_res = '0;
      m_last_rd = '0;
    end else begin
      k   = cyc - m_t0;
      dk  = m_spec ? 1 : 34;
      acc = !m_act && start_i && !flush_i;
      be  = acc || (m_act && !m_spec && k >= 1 && k <= 33);
      de  = m_act && k == dk && !flush_i;
      chk("busy", busy_o, be);
      chk("done", done_o, de);
      chk("result", result_o, (m_act && k >= dk) ? m_res : m_last_res);
      chk("rd", rd_addr_o, m_act ? m_rd : m_last_rd);
      if (m_act && (flush_i || k >= dk)) begin
        if (k >= dk) m_last_res = m_res;
        m_last_rd = m_rd;
        m_act = 0;
      end
      if (acc) begin
        m_act  = 1;
        m_t0   = cyc;
        m_spec = is_special(op_i, dividend_i, divisor_i);
        m_res  = ref_result(op_i, dividend_i, divisor_i);
        m_rd   = rd_addr_i;
      end
    end
  end

  task automatic run_op(string name, logic [1:0] op, logic [31:0] a,
                        logic [31:0] b, logic [4:0] rd,
                        logic [31:0] lit, int lat);
    int n;
    @(posedge clk); #1;
    start_i = 1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    @(posedge clk); #1;
    start_i = 0;
    n = 1;
    while (!done_o && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_res"}, result_o, lit);
    chk({name, "_lat"}, n, lat);
    chk({name, "_rd"}, rd_addr_o, rd);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4,
           32'hFFFF_FFFF, 34);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5,
           32'hFFFF_FFFD, 34);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,
           32'h8000_0000, 1);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,
           32'h0, 1);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd9, 32'd5, 1);
    run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd10,
           32'hFFFF_FFF2, 34);
    run_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 5'd11,
           32'd2, 34);
    run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'd10, 5'd12, 32'd5, 34);

    // abort in CALC iteration 10, with a stray start that must be ignored
    @(posedge clk); #1;
    start_i = 1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3;
    rd_addr_i = 5'd13;
    @(posedge clk); #1;
    start_i = 0;
    repeat (4) @(posedge clk);
    #1 start_i = 1; dividend_i = 32'd77;
    @(posedge clk); #1 start_i = 0;
    repeat (4) @(posedge clk);
    #1 flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0;
    chk("flush_busy", busy_o, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) seen = 1;
    end
    chk("flush_nodone", seen, 0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd14, 32'd3, 34);

    // asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    start_i = 1; op_i = 2'b00; dividend_i = 32'd1000; divisor_i = 32'd7;
    rd_addr_i = 5'd15;
    @(posedge clk); #1;
    start_i = 0;
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_busy", busy_o, 0);
    chk("async_done", done_o, 0);
    chk("async_result", result_o, 0);
    chk("async_rd", rd_addr_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_op("div_20_4", 2'b00, 32'd20, 32'd4, 5'd16, 32'd5, 34);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rooth_div_ctrl.md
ROOTH_DIV_CTRL -- requirements
Module: rooth_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, number of CALC iterations; one quotient bit per cycle; fixed equal to `CPU_WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  divide request from EX stage.
REQ-005 SHALL have port op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port dividend_i  input  32  rs1 value.
REQ-007 SHALL have port divisor_i  input  32  rs2 value.
REQ-008 SHALL have port rd_addr_i  input  5  destination register.
REQ-009 SHALL have port flush_i  input  1  abort request (jump, interrupt).
REQ-010 SHALL have port busy_o  output  1  pipeline hold request.
REQ-011 SHALL have port done_o  output  1  one-cycle result-valid and write-enable pulse.
REQ-012 SHALL have port result_o  output  32  quotient or remainder.
REQ-013 SHALL have port rd_addr_o  output  5  latched destination register.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-015 SHALL accept start_i only in IDLE with flush_i low, latching op, operands and rd_addr on that edge.
REQ-016 SHALL ignore start_i in any state other than IDLE.
REQ-017 SHALL go IDLE->CALC on a normal accept.
REQ-018 SHALL stay in CALC exactly DIV_CYCLES cycles, then go to FIX for 1 cycle, then DONE for 1 cycle, then IDLE.
REQ-019 SHALL give normal latency as follows: accept edge E0 -> done_o high during cycle 34 after E0.
REQ-020 SHALL treat divisor==0 and signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) as special cases, going IDLE->DONE directly with done_o high in the cycle after accept.
REQ-021 SHALL produce divide-by-zero results: DIV/DIVU 0xFFFFFFFF; REM/REMU = dividend.
REQ-022 SHALL produce overflow results: DIV 0x80000000; REM 0.
REQ-023 SHALL perform signed ops on operand magnitudes with restoring shift-subtract.
REQ-024 SHALL, in FIX, negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-025 SHALL keep unsigned ops bypassing sign handling; all arithmetic is 32-bit with a 33-bit partial remainder.
REQ-026 SHALL drive busy_o combinationally high when start_i is accepted in IDLE, and high throughout CALC and FIX.
REQ-027 SHALL drive busy_o low in DONE and in IDLE without an accept.
REQ-028 SHALL drive done_o = (state==DONE) && !flush_i.
REQ-029 SHALL hold result_o and rd_addr_o stable from DONE until the next accept.
REQ-030 SHALL, on flush_i high in any state, make the next state IDLE, discard the operation and emit no done_o.
REQ-031 SHALL, on flush_i together with start_i in IDLE, not accept.
REQ-032 SHALL allow back-to-back operation: a start_i in the cycle after DONE (state IDLE) is accepted.

Reset
REQ-033 SHALL on rst_n low immediately force state IDLE, busy_o 0, done_o 0, result_o 0, rd_addr_o 0, and clear the iteration counter and datapath registers.
REQ-034 SHALL on reset mid-operation abandon the operation silently; after rst_n rises the first start_i is accepted normally.

Structure
REQ-035 SHALL take `CPU_WIDTH and op_i encodings (DIV/DIVU/REM/REMU) from the shared rooth_defines.v.
REQ-036 SHALL place the single-iteration compare/subtract/shift step in one combinational sub-module, rooth_div_step.
REQ-037 SHALL keep the FSM, counter, sign fix-up and special-case detection in rooth_div_ctrl.

Verification
REQ-038 SHALL cover: DIVU 100/7 -> result 14, done_o in cycle 34, busy_o high cycles 0-33.
REQ-039 SHALL cover: REM 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF; DIV same -> 0xFFFFFFFD.
REQ-040 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done_o 1 cycle after accept; REM same -> 0.
REQ-041 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both after 1 cycle.
REQ-042 SHALL cover: flush_i in CALC iteration 10 -> no done_o, busy_o low next cycle, new DIVU 9/3 then returns 3.
REQ-043 SHALL cover: rst_n low mid-CALC -> all outputs 0 asynchronously; post-reset DIV 20/4 -> 5.
